inst_fetch: RTL

Instruction-fetch unit that drives the instruction cache's query/update interface.
- Holds the PC and presents it to the cache every cycle.
- On a hit, forwards the instruction to the decoder.
- On a miss, runs a memory-controller request, then writes the returned word back into the cache.
- Also handles downstream stall and pipeline-clear redirect from the ROB.

---
 rtl/inst_fetch_pkg.sv | 7 +
 rtl/inst_fetch.sv | 70 +++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset PC and FSM state encoding for the fetch unit
package inst_fetch_pkg;
  localparam int IF_ADDR_W = 32;
  localparam int IF_INST_W = 32;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 32'h0000_0000;
  typedef enum logic {IF_IDLE, IF_WAIT_MEM} if_state_t;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, I-cache query/fill and memory-miss handling feeding the decoder
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int INST_W = IF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  output logic [ADDR_W-1:0] if_to_ic_fetch_addr,
  input  logic              ic_to_if_hit,
  input  logic [INST_W-1:0] ic_to_if_hit_inst,
  output logic [ADDR_W-1:0] if_to_ic_update_addr,
  output logic [INST_W-1:0] if_to_ic_inst,
  output logic              if_to_ic_inst_valid,
  output logic              if_to_mc_req,
  output logic [ADDR_W-1:0] if_to_mc_addr,
  input  logic              mc_to_if_done,
  input  logic [INST_W-1:0] mc_to_if_inst,
  input  logic              dec_to_if_stall,
  output logic              if_to_dec_inst_valid,
  output logic [INST_W-1:0] if_to_dec_inst,
  output logic [ADDR_W-1:0] if_to_dec_pc,
  input  logic              rob_to_if_clear,
  input  logic [ADDR_W-1:0] rob_to_if_redirect_pc
);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  if_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_addr;
  assign if_to_ic_fetch_addr  = pc;
  assign if_to_ic_update_addr = pend_addr;
  assign if_to_ic_inst        = mc_to_if_inst;
  assign if_to_ic_inst_valid  = (state == IF_WAIT_MEM) & mc_to_if_done & rdy_in;
  // A redirect during a miss keeps the read alive so the fill still lands; only the PC moves.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      pc                   <= RESET_PC & ALIGN;
      state                <= IF_IDLE;
      pend_addr            <= '0;
      if_to_mc_req         <= 1'b0;
      if_to_mc_addr        <= '0;
      if_to_dec_inst_valid <= 1'b0;
      if_to_dec_inst       <= '0;
      if_to_dec_pc         <= '0;
    end else if (rdy_in) begin
      if_to_dec_inst_valid <= 1'b0;
      if (rob_to_if_clear) pc <= rob_to_if_redirect_pc & ALIGN;
      if (state == IF_WAIT_MEM) begin
        if (mc_to_if_done) begin
          if_to_mc_req <= 1'b0;
          state        <= IF_IDLE;
        end
      end else if (!rob_to_if_clear && !dec_to_if_stall) begin
        if (ic_to_if_hit) begin
          if_to_dec_inst_valid <= 1'b1;
          if_to_dec_inst       <= ic_to_if_hit_inst;
          if_to_dec_pc         <= pc;
          pc                   <= pc + ADDR_W'(4);
        end else begin
          pend_addr     <= pc;
          if_to_mc_addr <= pc;
          if_to_mc_req  <= 1'b1;
          state         <= IF_WAIT_MEM;
        end
      end
    end
endmodule
